input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
Input front end for the traffic light system. It takes raw board switches and buttons and produces synchronized, debounced levels, single-cycle button press pulses, car-presence flags, and a sticky pedestrian request. The request is held until the traffic light controller acknowledges it. It sits between the board pins and the controller/timer in the top level, and replaces the direct pin-to-logic wiring.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronized input must differ from its stable value before it is accepted (10 ms at 100 MHz); legal range >= 1
N_SW, 8, number of switch inputs
N_BTN, 5, number of button inputs

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sw  input  N_SW  raw switches; [7:5] NS car sensors, [4:3] pedestrian, [2:0] EW car sensors
btn  input  N_BTN  raw buttons; [4] center, [2] down
ped_ack  input  1  single-cycle pulse from controller: pedestrian request serviced
sw_db  output  N_SW  debounced switch levels
btn_db  output  N_BTN  debounced button levels
btn_rise  output  N_BTN  one-cycle pulse per debounced 0->1 button edge
car_ns  output  1  OR of sw_db[7:5]
car_ew  output  1  OR of sw_db[2:0]
ped_req  output  1  sticky pedestrian request

Behaviour:
- Reset: asynchronous, active-low; one clock; no other clocks or enables.
- Reset values: all synchronizer flops, stable values, counters, sw_db, btn_db, btn_rise and ped_req are 0. car_ns and car_ew are therefore 0.
- Synchronizer: each of the N_SW+N_BTN inputs passes through two flops. The second flop output is sync[i].
- Debounce, per bit, with an independent counter of width $clog2(DEBOUNCE_CYCLES+1):
  - sync == stable: counter <= 0.
  - sync != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
- Debounce consequences:
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never reaches the output, and any return to the stable value restarts the count.
  - Latency from a clean pin edge to sw_db/btn_db change is exactly 2 + DEBOUNCE_CYCLES clk cycles.
  - DEBOUNCE_CYCLES=1 gives pure synchronization with 3-cycle latency.
- sw_db and btn_db are the stable registers, driven directly.
- btn_rise[i] is registered. It is high for exactly one cycle: the same cycle btn_db[i] first reads 1 after being 0. A held button produces no further pulses. Falling edges produce nothing.
- car_ns and car_ew are combinational ORs of registered sw_db bits. No added latency.
- ped_level = |sw_db[4:3]. ped_req behaviour:
  - Set: on the edge where ped_level transitions 0->1 (previous-cycle register of ped_level compared).
  - Clear: on an edge where ped_ack = 1 and no new set occurs that cycle.
  - Set and ack in the same cycle: ped_req stays/becomes 1, so the new request is not lost.
  - ped_ack while ped_req = 0: no effect.
  - ped_level held high after ack: does not re-set; a fresh 0->1 transition is required.
- Reset mid-debounce clears counters and outputs. An input still held after reset release re-qualifies after 2 + DEBOUNCE_CYCLES cycles and produces a btn_rise / ped_req set at that point.
- Power-on with a button held: it is reported as a press after qualification (a consequence of the 0 reset value).

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, then set sw[6]=1 cleanly at cycle 0 -> sw_db[6] and car_ns rise at cycle 6. car_ew stays 0. All outputs are 0 during reset.
- DEBOUNCE_CYCLES=4. btn[4] pulses high for 3 cycles, then low -> btn_db[4] and btn_rise[4] never assert. Then hold btn[4] high -> btn_rise[4] is high for exactly 1 cycle, coincident with btn_db[4] rising at +6. No further pulses while held.
- Bounce pattern on sw[0] (1,0,1,1,0,1,1,1,1 per cycle) -> sw_db[0] rises only after 4 consecutive synchronized 1s. car_ew follows in the same cycle.
- Set sw[3]=1 -> ped_req=1 after qualification and stays 1. Pulse ped_ack -> ped_req=0 next cycle and stays 0 while sw[3] is held. Toggle sw[3] 0 then 1 (each held 6+ cycles) -> ped_req re-asserts.
- Align ped_ack with the cycle ped_level rises -> ped_req ends at 1. Separately, ped_ack while ped_req=0 -> no change.
- Hold sw[7] and btn[2] high, assert reset_n=0 mid-count for 2 cycles -> all outputs 0 immediately (asynchronous). After release, sw_db[7]/btn_db[2] rise exactly 6 cycles later and btn_rise[2] pulses once.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Board-side bundle for the input conditioner: raw switches/buttons and the controller ack,
// plus the conditioned levels, press pulses, car flags and pedestrian request.
interface input_conditioner_if #(
    parameter int N_SW  = 8,
    parameter int N_BTN = 5
);
    logic [N_SW-1:0]  sw;
    logic [N_BTN-1:0] btn;
    logic             ped_ack;
    logic [N_SW-1:0]  sw_db;
    logic [N_BTN-1:0] btn_db;
    logic [N_BTN-1:0] btn_rise;
    logic             car_ns;
    logic             car_ew;
    logic             ped_req;

    modport master (
        output sw, btn, ped_ack,
        input  sw_db, btn_db, btn_rise, car_ns, car_ew, ped_req
    );

    modport slave (
        input  sw, btn, ped_ack,
        output sw_db, btn_db, btn_rise, car_ns, car_ew, ped_req
    );
endinterface

// File: rtl/input_conditioner.sv
// Two-flop synchronizer and per-bit debouncer for board switches/buttons, with button
// press pulses, car-presence flags and a sticky pedestrian request cleared by ped_ack.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int N_SW            = 8,
    parameter int N_BTN           = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input_conditioner_if.slave   bus
);
    localparam int N  = N_SW + N_BTN;
    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]     raw;
    logic [N-1:0]     meta_reg;
    logic [N-1:0]     sync_reg;
    logic [N-1:0]     stable_reg;
    logic [N-1:0]     commit;
    logic [N_BTN-1:0] btn_rise_reg;
    logic             ped_level;
    logic             ped_level_reg;
    logic             ped_set;
    logic             ped_req_reg;

    // Buttons occupy the upper bits so the switch indices line up with sw.
    assign raw = {bus.btn, bus.sw};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= raw;
            sync_reg <= meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_db
            logic [CW-1:0] cnt_reg;
            logic          stable_bit_reg;

            // The count only survives while the input keeps disagreeing with the stable value.
            assign commit[gi] = (sync_reg[gi] != stable_bit_reg) && (cnt_reg == CNT_LAST);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg        <= '0;
                    stable_bit_reg <= 1'b0;
                end else if (sync_reg[gi] == stable_bit_reg) begin
                    cnt_reg <= '0;
                end else if (commit[gi]) begin
                    stable_bit_reg <= sync_reg[gi];
                    cnt_reg        <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end

            assign stable_reg[gi] = stable_bit_reg;
        end
    endgenerate

    assign ped_level = |stable_reg[4:3];
    assign ped_set   = ped_level & ~ped_level_reg;

    // A press pulse is registered on the same edge the debounced level commits to 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_rise_reg  <= '0;
            ped_level_reg <= 1'b0;
            ped_req_reg   <= 1'b0;
        end else begin
            btn_rise_reg  <= commit[N-1:N_SW] & sync_reg[N-1:N_SW];
            ped_level_reg <= ped_level;
            // A new request wins over a same-cycle ack so it is never lost.
            if (ped_set) begin
                ped_req_reg <= 1'b1;
            end else if (bus.ped_ack) begin
                ped_req_reg <= 1'b0;
            end
        end
    end

    assign bus.sw_db    = stable_reg[N_SW-1:0];
    assign bus.btn_db   = stable_reg[N-1:N_SW];
    assign bus.btn_rise = btn_rise_reg;
    assign bus.car_ns   = |stable_reg[7:5];
    assign bus.car_ew   = |stable_reg[2:0];
    assign bus.ped_req  = ped_req_reg;
endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4: directed scenarios with
// fixed-latency expectations plus random stimulus against a window-based reference model.
module tb_input_conditioner;
    localparam int DEB   = 4;
    localparam int N_SW  = 8;
    localparam int N_BTN = 5;
    localparam int N     = N_SW + N_BTN;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    input_conditioner_if #(.N_SW(N_SW), .N_BTN(N_BTN)) bus ();

    input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .N_SW(N_SW),
        .N_BTN(N_BTN)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pins reach the debouncer two samples late; a level is accepted once the
    // last DEB synchronized samples all disagree with the currently accepted level.
    logic [N-1:0]     pin_hist[$];
    logic [N-1:0]     sync_hist[$];
    logic [N-1:0]     m_db;
    logic [N_BTN-1:0] m_rise;
    logic             m_ped_prev;
    logic             m_ped_req;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pin_hist.delete();
            sync_hist.delete();
            m_db       = '0;
            m_rise     = '0;
            m_ped_prev = 1'b0;
            m_ped_req  = 1'b0;
        end else begin
            logic [N-1:0] sync_now;
            logic [N-1:0] new_db;
            logic         lvl;
            sync_now = (pin_hist.size() >= 2) ? pin_hist[pin_hist.size() - 2] : '0;
            pin_hist.push_back({bus.btn, bus.sw});
            if (pin_hist.size() > 4) void'(pin_hist.pop_front());
            sync_hist.push_back(sync_now);
            if (sync_hist.size() > DEB) void'(sync_hist.pop_front());
            new_db = m_db;
            for (int b = 0; b < N; b++) begin
                bit all_diff;
                all_diff = (sync_hist.size() == DEB);
                for (int j = 0; j < sync_hist.size(); j++)
                    if (sync_hist[j][b] == m_db[b]) all_diff = 1'b0;
                if (all_diff) new_db[b] = ~m_db[b];
            end
            lvl = m_db[4] | m_db[3];
            if (lvl && !m_ped_prev) m_ped_req = 1'b1;
            else if (bus.ped_ack)   m_ped_req = 1'b0;
            m_ped_prev = lvl;
            m_rise = new_db[N-1:N_SW] & ~m_db[N-1:N_SW];
            m_db   = new_db;
        end
    end

    function automatic logic [20:0] exp_vec();
        return {m_db[N_SW-1:0], m_db[N-1:N_SW], m_rise, |m_db[7:5], |m_db[2:0], m_ped_req};
    endfunction

    function automatic logic [20:0] obs_vec();
        return {bus.sw_db, bus.btn_db, bus.btn_rise, bus.car_ns, bus.car_ew, bus.ped_req};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.sw      = '1;
        bus.btn     = '1;
        bus.ped_ack = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (obs_vec() !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs_vec());
        end
        bus.sw      = '0;
        bus.btn     = '0;
        bus.ped_ack = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_tests++;
            if (obs_vec() !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_idle: cycle %0d got %h expected 0", c, obs_vec());
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_clean_edge();
        bus.sw[6] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_tests++;
            if (bus.sw_db[6] !== (c >= 2 + DEB) || bus.car_ns !== (c >= 2 + DEB) || bus.car_ew !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_edge: cycle %0d got sw_db6=%b car_ns=%b car_ew=%b expected %b %b 0",
                         c, bus.sw_db[6], bus.car_ns, bus.car_ew, c >= 2 + DEB, c >= 2 + DEB);
            end
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL clean_edge_model: cycle %0d got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        $display("[TB] test_clean_edge done");
    endtask

    task automatic test_glitch_and_press();
        int pulses;
        bus.btn[4] = 1'b1;
        repeat (3) tick();
        bus.btn[4] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++;
            if (bus.btn_db[4] !== 1'b0 || bus.btn_rise[4] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch: cycle %0d got db=%b rise=%b expected 0 0", c, bus.btn_db[4], bus.btn_rise[4]);
            end
        end
        bus.btn[4] = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (bus.btn_rise[4] === 1'b1) pulses++;
            n_tests++;
            if (bus.btn_db[4] !== (c >= 2 + DEB) || bus.btn_rise[4] !== (c == 2 + DEB)) begin
                n_fail++;
                $display("FAIL press: cycle %0d got db=%b rise=%b expected %b %b",
                         c, bus.btn_db[4], bus.btn_rise[4], c >= 2 + DEB, c == 2 + DEB);
            end
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL press_model: cycle %0d got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL press_pulse_count: got %0d expected 1", pulses);
        end
        $display("[TB] test_glitch_and_press done");
    endtask

    task automatic test_bounce();
        logic [8:0] pat;
        pat = 9'b111101101;
        for (int c = 1; c <= 14; c++) begin
            bus.sw[0] = (c <= 9) ? pat[c-1] : 1'b1;
            tick();
            n_tests++;
            if (bus.sw_db[0] !== (c >= 11) || bus.car_ew !== (c >= 11)) begin
                n_fail++;
                $display("FAIL bounce: cycle %0d got sw_db0=%b car_ew=%b expected %b", c, bus.sw_db[0], bus.car_ew, c >= 11);
            end
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL bounce_model: cycle %0d got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        $display("[TB] test_bounce done");
    endtask

    task automatic test_ped();
        bus.sw[3] = 1'b1;
        repeat (12) tick();
        n_tests++;
        if (bus.ped_req !== 1'b1 || m_ped_req !== 1'b1) begin
            n_fail++;
            $display("FAIL ped_set: got %b model %b expected 1", bus.ped_req, m_ped_req);
        end
        bus.ped_ack = 1'b1;
        tick();
        bus.ped_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (bus.ped_req !== 1'b0) begin
                n_fail++;
                $display("FAIL ped_ack_clear: cycle %0d got %b expected 0", c, bus.ped_req);
            end
            tick();
        end
        bus.sw[3] = 1'b0;
        repeat (8) tick();
        bus.sw[3] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ped_retoggle_model: cycle %0d got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (bus.ped_req !== 1'b1) begin
            n_fail++;
            $display("FAIL ped_reassert: got %b expected 1", bus.ped_req);
        end
        $display("[TB] test_ped done");
    endtask

    task automatic test_ack_collision();
        bit seen;
        bus.ped_ack = 1'b1;
        tick();
        bus.ped_ack = 1'b0;
        bus.sw[3]   = 1'b0;
        repeat (8) tick();
        bus.sw[3] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            if (bus.sw_db[3] === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL collide_wait: sw_db[3] got 0 expected 1 within 12 cycles");
        end
        bus.ped_ack = 1'b1;
        tick();
        bus.ped_ack = 1'b0;
        n_tests++;
        if (bus.ped_req !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_set_wins: got %b expected 1", bus.ped_req);
        end
        bus.ped_ack = 1'b1;
        tick();
        n_tests++;
        if (bus.ped_req !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_clear: got %b expected 0", bus.ped_req);
        end
        tick();
        bus.ped_ack = 1'b0;
        tick();
        n_tests++;
        if (bus.ped_req !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL idle_ack: got %h expected %h", obs_vec(), exp_vec());
        end
        $display("[TB] test_ack_collision done");
    endtask

    task automatic test_reset_mid();
        int pulses;
        bus.sw[7]  = 1'b1;
        bus.btn[2] = 1'b1;
        repeat (3) tick();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (obs_vec() !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", obs_vec());
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pulses  = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (bus.btn_rise[2] === 1'b1) pulses++;
            n_tests++;
            if (bus.sw_db[7] !== (c >= 2 + DEB) || bus.btn_db[2] !== (c >= 2 + DEB) ||
                bus.btn_rise[2] !== (c == 2 + DEB)) begin
                n_fail++;
                $display("FAIL requalify: cycle %0d got sw_db7=%b btn_db2=%b rise2=%b expected %b %b %b", c,
                         bus.sw_db[7], bus.btn_db[2], bus.btn_rise[2], c >= 2 + DEB, c >= 2 + DEB, c == 2 + DEB);
            end
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL requalify_model: cycle %0d got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL requalify_pulses: got %0d expected 1", pulses);
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_random();
        logic [N-1:0] pins;
        int           errs;
        pins = {bus.btn, bus.sw};
        errs = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) pins[$urandom_range(0, N - 1)] ^= 1'b1;
            bus.sw      = pins[N_SW-1:0];
            bus.btn     = pins[N-1:N_SW];
            bus.ped_ack = ($urandom_range(0, 7) == 0);
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random: cycle %0d got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        bus.ped_ack = 1'b0;
        $display("[TB] test_random done");
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        bus.sw      = '0;
        bus.btn     = '0;
        bus.ped_ack = 1'b0;
        reset_n     = 1'b0;
        test_reset();
        test_clean_edge();
        test_glitch_and_press();
        test_bounce();
        test_ped();
        test_ack_collision();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
